// File: rtl/regfile_traffic_gen.sv
// On-chip traffic generator driving a regfile read/write port: sequential fill,
// checked readback, LFSR random mix and an idle baseline, with a saturating error count.
module regfile_traffic_gen #(
  parameter int          N          = 32,
  parameter int          WIDTH      = 32,
  parameter int          ADDR_WIDTH = $clog2(N),
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [15:0]           num_ops,
  output logic [ADDR_WIDTH-1:0] R_addr,
  output logic                  R_en,
  input  logic [WIDTH-1:0]      R_data,
  output logic [ADDR_WIDTH-1:0] W_addr,
  output logic                  W_en,
  output logic [WIDTH-1:0]      W_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           err_count
);

  localparam logic [31:0]           TAPS      = 32'h80200003;
  localparam logic [31:0]           SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0]   N_WIDE    = (ADDR_WIDTH + 1)'(N);
  localparam logic [ADDR_WIDTH-1:0] N_NARROW  = ADDR_WIDTH'(N);
  localparam int                    PAT_REPS  = WIDTH / ADDR_WIDTH + 1;
  localparam int                    LFSR_REPS = WIDTH / 32 + 1;
  localparam int                    ODD_REPS  = WIDTH / 2 + 1;
  localparam logic [2*ODD_REPS-1:0] ODD_FULL  = {ODD_REPS{2'b10}};
  localparam logic [WIDTH-1:0]      ODD_MASK  = ODD_FULL[WIDTH-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Bit i is a[i mod ADDR_WIDTH], inverted on odd bit positions.
  function automatic logic [WIDTH-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    logic [PAT_REPS*ADDR_WIDTH-1:0] rep;
    rep = {PAT_REPS{a}};
    return rep[WIDTH-1:0] ^ ODD_MASK;
  endfunction

  function automatic logic [WIDTH-1:0] rep_lfsr(input logic [31:0] l);
    logic [LFSR_REPS*32-1:0] rep;
    rep = {LFSR_REPS{l}};
    return rep[WIDTH-1:0];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
    if ({1'b0, a} >= N_WIDE) return a - N_NARROW;
    return a;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
  endfunction

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [15:0]           r_num_ops;
  logic [15:0]           r_idx;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [31:0]           r_lfsr;
  logic                  r_ren;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ren_d;
  logic [ADDR_WIDTH-1:0] r_raddr_d;
  logic [15:0]           r_err;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_issue;
  logic [1:0]            w_op_mode;
  logic [ADDR_WIDTH-1:0] w_op_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_op_ren;
  logic                  w_op_wen;
  logic [ADDR_WIDTH-1:0] w_op_raddr;
  logic [ADDR_WIDTH-1:0] w_op_waddr;
  logic [WIDTH-1:0]      w_op_wdata;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_idx == r_num_ops - 16'd1);
  assign w_issue    = (w_accept && (num_ops != 16'd0)) || ((r_state == S_RUN) && !w_last);
  // Op 0 is issued from IDLE, so it must use the incoming mode and a cleared counter.
  assign w_op_mode  = (r_state == S_IDLE) ? mode : r_mode;
  assign w_op_addr  = (r_state == S_IDLE) ? '0 : r_cnt;
  assign w_addr_nxt = (w_op_addr == LAST_ADDR) ? '0 : w_op_addr + 1'b1;

  always_comb begin
    w_op_ren   = 1'b0;
    w_op_wen   = 1'b0;
    w_op_raddr = '0;
    w_op_waddr = '0;
    w_op_wdata = '0;
    case (w_op_mode)
      2'd0: begin
        w_op_wen   = 1'b1;
        w_op_waddr = w_op_addr;
        w_op_wdata = pat(w_op_addr);
      end
      2'd1: begin
        w_op_ren   = 1'b1;
        w_op_raddr = w_op_addr;
      end
      2'd2: begin
        w_op_ren   = r_lfsr[0];
        w_op_wen   = r_lfsr[1];
        w_op_raddr = map_addr(r_lfsr[ADDR_WIDTH+1:2]);
        w_op_waddr = map_addr(r_lfsr[2*ADDR_WIDTH+1:ADDR_WIDTH+2]);
        w_op_wdata = rep_lfsr(r_lfsr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mode    <= 2'd0;
      r_num_ops <= 16'd0;
      r_idx     <= 16'd0;
      r_cnt     <= '0;
      r_lfsr    <= SEED_EFF;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_raddr   <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode    <= mode;
            r_num_ops <= num_ops;
            r_idx     <= 16'd0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= (num_ops == 16'd0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_last) r_state <= S_DRAIN;
          else        r_idx   <= r_idx + 16'd1;
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // Outputs carry an op only while one is being issued; otherwise they rest at 0.
      if (w_issue) begin
        r_ren   <= w_op_ren;
        r_wen   <= w_op_wen;
        r_raddr <= w_op_raddr;
        r_waddr <= w_op_waddr;
        r_wdata <= w_op_wdata;
        if (w_op_mode == 2'd0 || w_op_mode == 2'd1) r_cnt <= w_addr_nxt;
        if (w_op_mode == 2'd2) r_lfsr <= lfsr_next(r_lfsr);
      end else begin
        r_ren   <= 1'b0;
        r_wen   <= 1'b0;
        r_raddr <= '0;
        r_waddr <= '0;
        r_wdata <= '0;
      end
    end
  end

  // Read data returns one cycle after R_en, so compare against the delayed address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ren_d   <= 1'b0;
      r_raddr_d <= '0;
      r_err     <= 16'd0;
    end else begin
      r_ren_d   <= r_ren;
      r_raddr_d <= r_raddr;
      if (w_accept) begin
        r_err <= 16'd0;
      end else if ((r_mode == 2'd1) && r_ren_d && (R_data != pat(r_raddr_d))
                   && (r_err != 16'hFFFF)) begin
        r_err <= r_err + 16'd1;
      end
    end
  end

  assign R_en      = r_ren;
  assign W_en      = r_wen;
  assign R_addr    = r_raddr;
  assign W_addr    = r_waddr;
  assign W_data    = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err;

endmodule

// File: tb/tb_regfile_traffic_gen.sv
// Directed bench for regfile_traffic_gen with N=8, WIDTH=8 and a behavioural regfile.
module tb_regfile_traffic_gen;

  localparam int LIMIT = 250;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] num_ops = 16'd0;
  logic [2:0]  R_addr;
  logic        R_en;
  logic [7:0]  R_data = 8'h00;
  logic [2:0]  W_addr;
  logic        W_en;
  logic [7:0]  W_data;
  logic        busy;
  logic        done;
  logic [15:0] err_count;

  regfile_traffic_gen #(.N(8), .WIDTH(8), .SEED(32'h1)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_ops(num_ops),
    .R_addr(R_addr), .R_en(R_en), .R_data(R_data),
    .W_addr(W_addr), .W_en(W_en), .W_data(W_data),
    .busy(busy), .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Regfile model with synchronous read; force5 corrupts reads of address 5.
  logic [7:0] mem [0:7];
  logic       force5 = 1'b0;
  always @(posedge clk) begin
    if (W_en) mem[W_addr] <= W_data;
    if (R_en) R_data <= (force5 && R_addr == 3'd5) ? 8'h00 : mem[R_addr];
  end

  // pat(a) for a = 0..7 with ADDR_WIDTH=3, WIDTH=8, worked out by hand.
  logic [7:0] PAT [0:7] = '{8'hAA, 8'hE3, 8'h38, 8'h71, 8'h8E, 8'hC7, 8'h1C, 8'h55};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       s_wen   [0:LIMIT-1];
  logic       s_ren   [0:LIMIT-1];
  logic [2:0] s_waddr [0:LIMIT-1];
  logic [2:0] s_raddr [0:LIMIT-1];
  logic [7:0] s_wdata [0:LIMIT-1];
  int         busy_cnt;
  int         done_at;
  int         done_cnt;
  logic       any_en;

  // Launches one sequence and samples every cycle after E0 until busy falls.
  task automatic run_seq(input logic [1:0] m, input logic [15:0] n, input int pulse_at);
    int c;
    mode = m; num_ops = n; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0; done_at = -1; done_cnt = 0; any_en = 1'b0;
    for (c = 0; c < LIMIT; c++) begin
      s_wen[c] = W_en; s_ren[c] = R_en; s_waddr[c] = W_addr;
      s_raddr[c] = R_addr; s_wdata[c] = W_data;
      if (W_en || R_en) any_en = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (!busy) break;
      busy_cnt++;
      start = (c == pulse_at);
      tick();
    end
    start = 1'b0;
    chk("seq_timeout", 32'(c < LIMIT), 32'd1);
  endtask

  initial begin
    int dn;
    tick(); tick();
    chk("rst_wen", 32'(W_en), 32'd0);
    chk("rst_ren", 32'(R_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick();

    // Sequential fill of all 8 entries
    run_seq(2'd0, 16'd8, -1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("m0_wen%0d", k), 32'(s_wen[k]), 32'd1);
      chk($sformatf("m0_waddr%0d", k), 32'(s_waddr[k]), 32'(k));
      chk($sformatf("m0_wdata%0d", k), 32'(s_wdata[k]), 32'(PAT[k]));
      chk($sformatf("m0_ren%0d", k), 32'(s_ren[k]), 32'd0);
    end
    chk("m0_drain_wen", 32'(s_wen[8]), 32'd0);
    chk("m0_done_at", 32'(done_at), 32'd9);
    chk("m0_done_cnt", 32'(done_cnt), 32'd1);
    chk("m0_busy_cnt", 32'(busy_cnt), 32'd10);

    // Clean readback
    run_seq(2'd1, 16'd8, -1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("m1_ren%0d", k), 32'(s_ren[k]), 32'd1);
      chk($sformatf("m1_raddr%0d", k), 32'(s_raddr[k]), 32'(k));
      chk($sformatf("m1_wen%0d", k), 32'(s_wen[k]), 32'd0);
    end
    chk("m1_done_at", 32'(done_at), 32'd9);
    chk("m1_err", 32'(err_count), 32'd0);

    // Readback with address 5 corrupted
    force5 = 1'b1;
    run_seq(2'd1, 16'd8, -1);
    chk("m1f_done_at", 32'(done_at), 32'd9);
    chk("m1f_err", 32'(err_count), 32'd1);
    tick(); tick();
    chk("m1f_err_hold", 32'(err_count), 32'd1);
    force5 = 1'b0;

    // Fill longer than depth: address wraps, err_count cleared on start
    mode = 2'd0; num_ops = 16'd20; start = 1'b1;
    tick();
    start = 1'b0;
    chk("m0w_err_clr", 32'(err_count), 32'd0);
    repeat (30) tick();
    run_seq(2'd0, 16'd20, -1);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("m0w_waddr%0d", k), 32'(s_waddr[k]), 32'(k % 8));
      chk($sformatf("m0w_wdata%0d", k), 32'(s_wdata[k]), 32'(PAT[k % 8]));
    end
    chk("m0w_busy_cnt", 32'(busy_cnt), 32'd22);
    chk("m0w_done_at", 32'(done_at), 32'd21);

    // Zero-length sequence
    run_seq(2'd0, 16'd0, -1);
    chk("z_any_en", 32'(any_en), 32'd0);
    chk("z_done_at", 32'(done_at), 32'd1);
    chk("z_busy_cnt", 32'(busy_cnt), 32'd2);

    // Idle baseline
    run_seq(2'd3, 16'd3, -1);
    chk("m3_any_en", 32'(any_en), 32'd0);
    chk("m3_busy_cnt", 32'(busy_cnt), 32'd5);
    chk("m3_done_at", 32'(done_at), 32'd4);

    // Reset during op 3 of a readback
    mode = 2'd1; num_ops = 16'd8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("rm_ren_before", 32'(R_en), 32'd1);
    chk("rm_raddr_before", 32'(R_addr), 32'd3);
    reset = 1'b1;
    #1;
    chk("rm_ren", 32'(R_en), 32'd0);
    chk("rm_raddr", 32'(R_addr), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_err", 32'(err_count), 32'd0);
    tick();
    reset = 1'b0;
    dn = 0;
    repeat (12) begin
      tick();
      if (done || busy) dn++;
    end
    chk("rm_no_done", 32'(dn), 32'd0);
    run_seq(2'd1, 16'd8, -1);
    chk("rm_fresh_done_at", 32'(done_at), 32'd9);
    chk("rm_fresh_err", 32'(err_count), 32'd0);

    // LFSR mix from seed, with a start pulse during RUN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    run_seq(2'd2, 16'd4, 2);
    chk("m2_ren0", 32'(s_ren[0]), 32'd1);
    chk("m2_wen0", 32'(s_wen[0]), 32'd0);
    chk("m2_raddr0", 32'(s_raddr[0]), 32'd0);
    chk("m2_wdata0", 32'(s_wdata[0]), 32'h01);
    chk("m2_ren1", 32'(s_ren[1]), 32'd1);
    chk("m2_wen1", 32'(s_wen[1]), 32'd1);
    chk("m2_wdata1", 32'(s_wdata[1]), 32'h03);
    chk("m2_ren2", 32'(s_ren[2]), 32'd0);
    chk("m2_wen2", 32'(s_wen[2]), 32'd1);
    chk("m2_wdata2", 32'(s_wdata[2]), 32'h02);
    chk("m2_ren3", 32'(s_ren[3]), 32'd1);
    chk("m2_wen3", 32'(s_wen[3]), 32'd0);
    chk("m2_busy_cnt", 32'(busy_cnt), 32'd6);
    chk("m2_done_cnt", 32'(done_cnt), 32'd1);
    chk("m2_err", 32'(err_count), 32'd0);
    tick(); tick();
    chk("m2_idle_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
